detect_sequence_programmable_fsm: RTL and testbench

Run-time-programmable serial bit-sequence detector. It generalises the fixed 4-bit and 6-bit detectors to any pattern of 1..MAX_LEN bits, with an input-valid qualifier, selectable overlapping or non-overlapping matching, and a saturating match counter. It sits on a serial bit stream and signals each completed pattern to downstream control logic.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/sequence_match_core.sv | 58 +++++
 rtl/detect_sequence_programmable_fsm.sv | 135 +++++++++++++
 tb/tb_detect_sequence_programmable_fsm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and helpers for the programmable sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int LEN_T_W = 8;

  typedef logic [LEN_T_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HUNT  = 2'd1,
    ST_MATCH = 2'd2
  } state_t;

  // Lengths beyond the physical pattern register saturate at its depth.
  function automatic len_t clamp_len(input len_t len, input len_t max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sequence_match_core.sv
// ============================================================================
// Module      : sequence_match_core
// Description : Combinational suffix/prefix matcher returning next progress
//               and a pattern-complete flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [LEN_W-1:0]   k,
  output logic [LEN_W-1:0]   next_k,
  output logic               complete
);

  logic [LEN_W-1:0]   w_limit;
  logic [MAX_LEN-1:0] w_cand;

  // A new match can be at most one bit longer than the current progress.
  assign w_limit = k + LEN_W'(1);

  // hist[0] is the newest bit; candidate j compares the newest j bits with
  // the first j pattern bits, pattern[len-1 -: j].
  for (genvar j = 1; j <= MAX_LEN; j++) begin : g_cand
    localparam logic [MAX_LEN-1:0] c_mask = {MAX_LEN{1'b1}} >> (MAX_LEN - j);
    localparam logic [LEN_W-1:0]   c_j    = LEN_W'(j);

    logic               w_fits;
    logic [LEN_W-1:0]   w_shamt;
    logic [MAX_LEN-1:0] w_pfx;

    assign w_fits      = (c_j <= len) && (c_j <= w_limit);
    assign w_shamt     = w_fits ? (len - c_j) : '0;
    assign w_pfx       = pattern >> w_shamt;
    assign w_cand[j-1] = w_fits && (((hist ^ w_pfx) & c_mask) == '0);
  end

  always_comb begin
    next_k   = '0;
    complete = 1'b0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (w_cand[j-1]) begin
        if (LEN_W'(j) == len) complete = 1'b1;
        else                  next_k   = LEN_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/detect_sequence_programmable_fsm.sv
// ============================================================================
// Module      : detect_sequence_programmable_fsm
// Description : Run-time programmable serial sequence detector with overlap
//               control and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module detect_sequence_programmable_fsm
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN     = 16,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 16'b1010,
  parameter int               DEF_LEN     = 4,
  parameter logic             DEF_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         en,
  input  logic                         a,
  input  logic                         cnt_clr,
  output logic                         detected,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [LEN_W-1:0] C_DEF_LEN =
    LEN_W'(clamp_len(len_t'(DEF_LEN), len_t'(MAX_LEN)));
  localparam state_t C_RST_STATE = (C_DEF_LEN == '0) ? ST_OFF : ST_HUNT;

  state_t             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [LEN_W-1:0]   r_k, w_k_nxt;
  logic [MAX_LEN-2:0] r_hist, w_hist_nxt;
  logic [CNT_W-1:0]   r_cnt;

  logic [LEN_W-1:0]   w_cfg_len;
  logic [MAX_LEN-1:0] w_hist_sh;
  logic [LEN_W-1:0]   w_core_k;
  logic               w_complete;
  logic               w_hit;

  assign w_cfg_len = LEN_W'(clamp_len(len_t'(cfg_len), len_t'(MAX_LEN)));
  assign w_hist_sh = {r_hist, a};

  sequence_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .hist     (w_hist_sh),
    .pattern  (r_pattern),
    .len      (r_len),
    .k        (r_k),
    .next_k   (w_core_k),
    .complete (w_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= C_DEF_LEN;
      r_overlap <= DEF_OVERLAP;
    end else if (cfg_we) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_cfg_len;
      r_overlap <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_RST_STATE;
      r_k     <= '0;
      r_hist  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_hist  <= w_hist_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_hist_nxt  = r_hist;
    w_hit       = 1'b0;
    if (cfg_we) begin
      // Reconfiguration wins over any bit presented at the same edge.
      w_state_nxt = (w_cfg_len == '0) ? ST_OFF : ST_HUNT;
      w_k_nxt     = '0;
      w_hist_nxt  = '0;
    end else begin
      case (r_state)
        ST_HUNT, ST_MATCH: begin
          if (en) begin
            w_hist_nxt = w_hist_sh[MAX_LEN-2:0];
            if (w_complete) begin
              w_hit       = 1'b1;
              w_state_nxt = ST_MATCH;
              w_k_nxt     = r_overlap ? w_core_k : '0;
            end else begin
              w_state_nxt = ST_HUNT;
              w_k_nxt     = w_core_k;
            end
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
        default: w_state_nxt = (r_len == '0) ? ST_OFF : ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (cnt_clr)            r_cnt <= '0;
    else if (w_hit && !cnt_sat)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign detected  = (r_state == ST_MATCH);
  assign match_cnt = r_cnt;
  assign cnt_sat   = &r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_detect_sequence_programmable_fsm.sv
// ============================================================================
// Module      : tb_detect_sequence_programmable_fsm
// Description : Directed self-checking bench for the programmable detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detect_sequence_programmable_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;
  logic        en;
  logic        a;
  logic        cnt_clr;
  logic        detected, detected2;
  logic [7:0]  match_cnt;
  logic [1:0]  match_cnt2;
  logic        cnt_sat, cnt_sat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  detect_sequence_programmable_fsm #(.MAX_LEN(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .a(a),
    .cnt_clr(cnt_clr), .detected(detected), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat)
  );

  detect_sequence_programmable_fsm #(.MAX_LEN(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .a(a),
    .cnt_clr(cnt_clr), .detected(detected2), .match_cnt(match_cnt2),
    .cnt_sat(cnt_sat2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic exp_det, input string tag);
    a  = b;
    en = v;
    @(posedge clk);
    #1;
    check(tag, {31'b0, detected}, {31'b0, exp_det});
  endtask

  task automatic cfg(input logic [15:0] p, input logic [4:0] l, input logic ov,
                     input logic clr, input logic b, input logic v);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cnt_clr     = clr;
    a           = b;
    en          = v;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
    en      = 1'b0;
    check("cfg_det", {31'b0, detected}, 32'd0);
  endtask

  // Bit i of the stream is s[n-1-i]; ex marks the bits after which a pulse is due.
  task automatic run_stream(input logic [31:0] s, input logic [31:0] ex, input int n,
                            input string tag);
    for (int i = 0; i < n; i++) step(s[n-1-i], 1'b1, ex[n-1-i], tag);
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; en = 1'b0; a = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_det", {31'b0, detected}, 32'd0);
    check("rst_cnt", {24'b0, match_cnt}, 32'd0);
    check("rst_sat", {31'b0, cnt_sat}, 32'd0);
    check("rst_sat2", {31'b0, cnt_sat2}, 32'd0);
    rst_n = 1'b1;

    // Default pattern 1010, overlapping
    run_stream(32'b0011_0101_1001_1001_1010_1000, 32'b0000_0010_0000_0000_0001_0100, 24, "ov1010");
    check("cnt_ov1010", {24'b0, match_cnt}, 32'd3);

    cfg(16'b1010, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    run_stream(32'b0011_0101_1001_1001_1010_1000, 32'b0000_0010_0000_0000_0001_0000, 24, "nov1010");
    check("cnt_nov1010", {24'b0, match_cnt}, 32'd2);

    cfg(16'b110011, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(32'b0011_0101_1001_1001_1010_1000, 32'b0000_0000_0000_1000_1000_0000, 24, "ov110011");
    check("cnt_110011", {24'b0, match_cnt}, 32'd2);

    // Gaps with en low must neither advance nor reset progress
    cfg(16'b1010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, "gap0");
    step(1'b0, 1'b0, 1'b0, "gap1");
    step(1'b0, 1'b1, 1'b0, "gap2");
    step(1'b1, 1'b0, 1'b0, "gap3");
    step(1'b1, 1'b1, 1'b0, "gap4");
    step(1'b1, 1'b0, 1'b0, "gap5");
    step(1'b0, 1'b1, 1'b1, "gap6");
    step(1'b0, 1'b0, 1'b0, "gap7");
    check("cnt_gap", {24'b0, match_cnt}, 32'd1);

    // Saturation on the 2-bit counter instance
    cfg(16'b11, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(32'hFF, 32'b0111_1111, 8, "ones");
    check("sat_cnt2", {30'b0, match_cnt2}, 32'd3);
    check("sat_flag2", {31'b0, cnt_sat2}, 32'd1);
    check("cnt7", {24'b0, match_cnt}, 32'd7);
    check("nosat8", {31'b0, cnt_sat}, 32'd0);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1, "clr_hit");
    cnt_clr = 1'b0;
    en      = 1'b0;
    check("clr_cnt2", {30'b0, match_cnt2}, 32'd0);
    check("clr_cnt", {24'b0, match_cnt}, 32'd0);
    check("clr_sat2", {31'b0, cnt_sat2}, 32'd0);

    // Reconfigure mid-pattern; bit offered at the cfg edge is dropped
    cfg(16'b1010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(32'b101, 32'b000, 3, "part101");
    cfg(16'b01, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    run_stream(32'b101, 32'b001, 3, "recfg01");
    check("cnt_recfg", {24'b0, match_cnt}, 32'd1);

    // Asynchronous reset while detected is high
    cfg(16'b0110, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    run_stream(32'b0110, 32'b0001, 4, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_det", {31'b0, detected}, 32'd0);
    check("arst_cnt", {24'b0, match_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_stream(32'b101010, 32'b000101, 6, "def_cfg");
    check("cnt_def", {24'b0, match_cnt}, 32'd2);

    // Length above MAX_LEN clamps to a full 16-bit pattern
    cfg(16'hA5C3, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(32'h0000_A5C3, 32'h0000_0001, 16, "len16");
    check("cnt_len16", {24'b0, match_cnt}, 32'd1);

    // Length zero disables detection; counter untouched
    cfg(16'h0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(32'h0000_FFA5, 32'h0, 16, "len0");
    check("cnt_len0", {24'b0, match_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
